// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console: register offsets within the
// 16-byte window, STATUS bit layout and the STATUS word builder.
package mmio_pkg;

    // Byte offsets of the registers inside the window (DataAdr[3:0] with [1:0] forced to 0)
    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CYCLE  = 4'h8;
    localparam logic [3:0] OFF_EXIT   = 4'hC;

    // STATUS bit positions
    localparam int ST_EMPTY   = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 4;

    // FIFO occupancy width: enough to hold a count of 16
    localparam int CNT_W = 5;

    // Assemble the STATUS read value; all unlisted bits read as zero
    function automatic logic [31:0] status_word(input logic             empty,
                                                input logic             full,
                                                input logic             ovf,
                                                input logic [CNT_W-1:0] cnt);
        logic [31:0] w;
        w                        = '0;
        w[ST_EMPTY]              = empty;
        w[ST_FULL]               = full;
        w[ST_OVF]                = ovf;
        w[ST_CNT_LSB +: CNT_W]   = cnt;
        return w;
    endfunction

endpackage

// File: rtl/mmio_fifo.sv
// Byte-wide TX FIFO. DEPTH must be a power of two (2..16) so the read and
// write pointers wrap naturally. A push is accepted when not full, or when
// full but a pop happens in the same cycle. The head byte reads as 0 when empty.
module mmio_fifo
    import mmio_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [7:0]       din_i,
    output logic [7:0]       dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign dout_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    // A pop is only meaningful with data present; a push may ride on a pop when full
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state: reset empties the FIFO by clearing pointers and count
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array: no reset needed, stale entries are unreachable once pointers clear
    always_ff @(posedge clk_i) begin
        if (do_push && !reset_i) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console peripheral: a 16-byte register window at BASE with
// a TX byte FIFO, sticky overflow flag, free-running cycle counter and an
// EXIT register that latches the program's completion code once.
module mmio_console
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE  = 32'h0000_FF00,
    parameter int          DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        TxValid,
    output logic [7:0]  TxData,
    input  logic        TxReady,
    output logic        Done,
    output logic [31:0] DoneCode
);

    logic             in_win;
    logic [3:0]       off;
    logic             wr_tx, wr_status, wr_exit;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;
    logic             ovf_set, ovf_clr;
    logic             ovf_q, ovf_d;
    logic [31:0]      cycle_q, cycle_d;
    logic             done_q, done_d;
    logic [31:0]      code_q, code_d;
    logic             unused_adr;

    // Window decode; byte-lane bits are ignored
    assign in_win     = (DataAdr[31:4] == BASE[31:4]);
    assign off        = {DataAdr[3:2], 2'b00};
    assign unused_adr = ^DataAdr[1:0];

    assign wr_tx     = MemWrite && in_win && (off == OFF_TXDATA);
    assign wr_status = MemWrite && in_win && (off == OFF_STATUS);
    assign wr_exit   = MemWrite && in_win && (off == OFF_EXIT);

    assign fifo_pop = TxValid && TxReady;

    mmio_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .reset_i (reset),
        .push_i  (wr_tx),
        .pop_i   (TxReady),
        .din_i   (WriteData[7:0]),
        .dout_o  (TxData),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign TxValid = !fifo_empty;

    // Overflow only when the byte would be dropped (full with no concurrent pop)
    assign ovf_set = wr_tx && fifo_full && !fifo_pop;
    assign ovf_clr = wr_status && WriteData[ST_OVF];

    // Next-state for OVF, CYCLE and EXIT; a fresh overflow beats a clear
    always_comb begin
        ovf_d   = ovf_q;
        cycle_d = cycle_q + 32'd1;
        done_d  = done_q;
        code_d  = code_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
        if (wr_exit && !done_q) begin
            done_d = 1'b1;
            code_d = WriteData;
        end
    end

    // Register state; reset clears everything so CYCLE reads 0 right after release
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q   <= 1'b0;
            cycle_q <= '0;
            done_q  <= 1'b0;
            code_q  <= '0;
        end else begin
            ovf_q   <= ovf_d;
            cycle_q <= cycle_d;
            done_q  <= done_d;
            code_q  <= code_d;
        end
    end

    assign Done     = done_q;
    assign DoneCode = code_q;

    // Combinational read mux; TXDATA and anything outside the window read 0
    always_comb begin
        ReadData = '0;
        if (in_win) begin
            case (off)
                OFF_STATUS: ReadData = status_word(fifo_empty, fifo_full, ovf_q, fifo_count);
                OFF_CYCLE:  ReadData = cycle_q;
                OFF_EXIT:   ReadData = {31'b0, done_q};
                default:    ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console: stimulus pushes expected TX bytes into a
// queue, and an independent monitor pops and compares on every handshake.
module tb_mmio_console;

    localparam logic [31:0] BASE = 32'h0000_FF00;
    localparam logic [31:0] A_TX = BASE + 32'h0;
    localparam logic [31:0] A_ST = BASE + 32'h4;
    localparam logic [31:0] A_CY = BASE + 32'h8;
    localparam logic [31:0] A_EX = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        TxValid;
    logic [7:0]  TxData;
    logic        TxReady;
    logic        Done;
    logic [31:0] DoneCode;

    int         nchk = 0;
    int         nerr = 0;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    mmio_console #(
        .BASE  (BASE),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .TxValid   (TxValid),
        .TxData    (TxData),
        .TxReady   (TxReady),
        .Done      (Done),
        .DoneCode  (DoneCode)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every accepted byte must match the head of the expected queue
    always @(negedge clk) begin
        if (reset === 1'b0 && TxValid === 1'b1 && TxReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL tx_unexpected: got 0x%02h, required no byte", TxData);
            end else begin
                logic [7:0] b;
                b = exp_q.pop_front();
                chk("tx_byte", 32'(TxData), 32'(b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        step();
        MemWrite  = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] b, input bit accept);
        if (accept) exp_q.push_back(b);
        store(A_TX, {24'h0, b});
    endtask

    task automatic read_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = a;
        @(negedge clk);
        chk(name, ReadData, exp);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = '0;
        WriteData = '0;
        TxReady   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state and cycle counter start
        read_chk("cycle_first", A_CY, 32'd0);
        read_chk("cycle_second", A_CY, 32'd1);
        chk("rst_txvalid", 32'(TxValid), 32'd0);
        chk("rst_txdata", 32'(TxData), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_donecode", DoneCode, 32'd0);
        read_chk("rst_status", A_ST, 32'h1);
        read_chk("txdata_reads_zero", A_TX, 32'h0);

        // Basic push and drain
        TxReady = 1'b1;
        push_tx(8'h48, 1'b1);
        push_tx(8'h69, 1'b1);
        idle(2);
        read_chk("basic_status", A_ST, 32'h1);
        chk("basic_drained", 32'(exp_q.size()), 32'd0);

        // Overflow with sink stalled; head held stable
        TxReady = 1'b0;
        push_tx(8'h41, 1'b1);
        push_tx(8'h42, 1'b1);
        push_tx(8'h43, 1'b1);
        push_tx(8'h44, 1'b1);
        push_tx(8'h45, 1'b0);
        read_chk("ovf_status", A_ST, 32'h46);
        chk("hold_valid", 32'(TxValid), 32'd1);
        chk("hold_data", 32'(TxData), 32'h41);
        read_chk("status_alias", BASE + 32'h7, 32'h46);
        chk("hold_data_later", 32'(TxData), 32'h41);

        // OVF clear only via bit2; then a new overflow sets it again
        store(A_ST, 32'hFFFF_FFFB);
        read_chk("ovf_no_clear", A_ST, 32'h46);
        store(A_ST, 32'h0000_0004);
        read_chk("ovf_cleared", A_ST, 32'h42);
        push_tx(8'h46, 1'b0);
        read_chk("ovf_set_again", A_ST, 32'h46);
        TxReady = 1'b1;
        idle(5);
        chk("ovf_drained", 32'(exp_q.size()), 32'd0);
        read_chk("ovf_sticky_empty", A_ST, 32'h5);
        store(A_ST, 32'h0000_0004);
        read_chk("ovf_clear_empty", A_ST, 32'h1);

        // Full FIFO with simultaneous push and pop
        TxReady = 1'b0;
        push_tx(8'h51, 1'b1);
        push_tx(8'h52, 1'b1);
        push_tx(8'h53, 1'b1);
        push_tx(8'h54, 1'b1);
        read_chk("full_status", A_ST, 32'h42);
        TxReady = 1'b1;
        push_tx(8'h5A, 1'b1);
        read_chk("pushpop_status", A_ST, 32'h42);
        idle(5);
        chk("pushpop_drained", 32'(exp_q.size()), 32'd0);
        read_chk("pushpop_final", A_ST, 32'h1);

        // EXIT latches once; FIFO keeps draining afterwards
        TxReady = 1'b0;
        push_tx(8'h61, 1'b1);
        push_tx(8'h62, 1'b1);
        store(A_EX, 32'h0000_002A);
        chk("exit_done", 32'(Done), 32'd1);
        chk("exit_code", DoneCode, 32'h2A);
        store(A_EX, 32'h0000_0007);
        chk("exit_code_kept", DoneCode, 32'h2A);
        read_chk("exit_read", A_EX, 32'h1);
        TxReady = 1'b1;
        idle(3);
        chk("exit_drained", 32'(exp_q.size()), 32'd0);
        chk("exit_done_kept", 32'(Done), 32'd1);

        // Reset mid-drain with a store and ready in the reset cycle
        TxReady = 1'b0;
        push_tx(8'h71, 1'b1);
        push_tx(8'h72, 1'b1);
        push_tx(8'h73, 1'b1);
        TxReady = 1'b1;
        step();
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = A_TX;
        WriteData = 32'h99;
        exp_q.delete();
        step();
        reset    = 1'b0;
        MemWrite = 1'b0;
        chk("mid_rst_txvalid", 32'(TxValid), 32'd0);
        chk("mid_rst_txdata", 32'(TxData), 32'd0);
        chk("mid_rst_done", 32'(Done), 32'd0);
        chk("mid_rst_code", DoneCode, 32'd0);
        read_chk("mid_rst_cycle0", A_CY, 32'd0);
        read_chk("mid_rst_cycle1", A_CY, 32'd1);

        // Stores and reads outside the window
        store(32'h0000_0100, 32'h0000_0033);
        store(32'h0000_010C, 32'h0000_0055);
        read_chk("outside_status", A_ST, 32'h1);
        chk("outside_txvalid", 32'(TxValid), 32'd0);
        chk("outside_done", 32'(Done), 32'd0);
        read_chk("outside_read", 32'h0000_0108, 32'h0);

        idle(2);
        chk("queue_empty_end", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", nchk, nerr);
        $finish;
    end

endmodule
